// File: rtl/rr_select_encoder4_if.sv
// Request/grant bundle between the requesters and the round-robin select encoder.
// The master modport belongs to the requesters; the slave modport belongs to the arbiter.
interface rr_select_encoder4_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       req;
  logic [1:0]       grant_idx;
  logic             grant_en;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req,
    input  grant_idx,
    input  grant_en,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output grant_idx,
    output grant_en,
    output hold_cnt
  );
endinterface

// File: rtl/rr_select_encoder4.sv
// Round-robin arbiter over four requests. Its registered winner index and enable drive
// the select and enable inputs of a 2-to-4 decoder, with a per-grant hold limit.
module rr_select_encoder4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_select_encoder4_if.slave  bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_LIMITED ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT     = {CNT_W{1'b1}};

  logic [0:0]       state_reg,     state_next;
  logic [1:0]       grant_idx_reg, grant_idx_next;
  logic [1:0]       ptr_reg,       ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg,  hold_cnt_next;

  logic [1:0] scan_base;
  logic [3:0] req_rot;
  logic [1:0] win_offset;
  logic       win_found;
  logic [1:0] winner;
  logic       grant_release;

  // While granted, the search starts just past the current holder, which is exactly the
  // pointer value a release would store, so the releasing index always scans last.
  assign scan_base = (state_reg == ST_GRANT) ? grant_idx_reg + 2'd1 : ptr_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = bus.req[scan_base + 2'(gi)];
  end

  always_comb begin
    win_found  = 1'b1;
    win_offset = 2'd0;
    casez (req_rot)
      4'b???1: win_offset = 2'd0;
      4'b??10: win_offset = 2'd1;
      4'b?100: win_offset = 2'd2;
      4'b1000: win_offset = 2'd3;
      default: win_found  = 1'b0;
    endcase
  end

  assign winner = scan_base + win_offset;

  assign grant_release = !bus.req[grant_idx_reg] ||
                         (HOLD_LIMITED && (hold_cnt_reg == HOLD_LAST));

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          state_next     = ST_GRANT;
          grant_idx_next = winner;
          hold_cnt_next  = '0;
        end
      end
      ST_GRANT: begin
        if (grant_release) begin
          ptr_next      = grant_idx_reg + 2'd1;
          hold_cnt_next = '0;
          if (win_found) begin
            grant_idx_next = winner;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (hold_cnt_reg != HOLD_SAT) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_idx_reg <= 2'd0;
      ptr_reg       <= 2'd0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign bus.grant_en  = (state_reg == ST_GRANT);
  assign bus.grant_idx = grant_idx_reg;
  assign bus.hold_cnt  = hold_cnt_reg;
endmodule
